// File: rtl/cpu_trace_emitter_if.sv
// Handshake and event bus between the CPU write-back stage and the trace emitter.
// ev_time carries the event time field; "time" itself is a reserved word.
interface cpu_trace_emitter_if;
    logic        start;
    logic        kind;
    logic [13:0] ev_time;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
    logic        char_ready;
    logic [7:0]  char;
    logic        char_valid;
    logic        busy;
    logic        done;

    modport master (
        output start, kind, ev_time, pc, grf, addr, data, char_ready,
        input  char, char_valid, busy, done
    );

    modport slave (
        input  start, kind, ev_time, pc, grf, addr, data, char_ready,
        output char, char_valid, busy, done
    );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back event into an ASCII trace line, one character per
// valid/ready handshake. Time is converted to BCD by a 14-step double-dabble.
module cpu_trace_emitter #(
    parameter int TIME_MAX = 9999
) (
    input logic clk,
    input logic reset,
    cpu_trace_emitter_if.slave bus
);
    localparam logic [13:0] TIME_SAT = 14'(TIME_MAX);

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
    state_t state;

    logic        kind_q;
    logic [4:0]  grf_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [29:0] dd;
    logic [3:0]  cnt;
    logic [5:0]  idx;
    logic [7:0]  char_q;
    logic        valid_q, busy_q, done_q;

    logic [15:0] bcd;
    logic [5:0]  t_len, g_len, rest, last, nidx;
    logic [3:0]  g_tens, g_ones, tdig;
    logic [1:0]  td;
    logic [7:0]  nxt;

    function automatic logic [13:0] sat_time(input logic [13:0] t);
        return (t > TIME_SAT) ? TIME_SAT : t;
    endfunction

    function automatic logic [29:0] dabble(input logic [29:0] v);
        logic [29:0] a;
        a = v;
        for (int i = 0; i < 4; i++)
            if (a[14+4*i +: 4] >= 4'd5) a[14+4*i +: 4] = a[14+4*i +: 4] + 4'd3;
        return {a[28:0], 1'b0};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Nibble j counted from the most significant end.
    function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] j);
        return 4'(w >> {~j, 2'b00});
    endfunction

    always_comb begin
        bcd = dd[29:14];
        if (bcd[15:12] != 4'd0)     t_len = 6'd4;
        else if (bcd[11:8] != 4'd0) t_len = 6'd3;
        else if (bcd[7:4] != 4'd0)  t_len = 6'd2;
        else                        t_len = 6'd1;

        if (grf_q >= 5'd30)      begin g_tens = 4'd3; g_ones = 4'(grf_q - 5'd30); end
        else if (grf_q >= 5'd20) begin g_tens = 4'd2; g_ones = 4'(grf_q - 5'd20); end
        else if (grf_q >= 5'd10) begin g_tens = 4'd1; g_ones = 4'(grf_q - 5'd10); end
        else                     begin g_tens = 4'd0; g_ones = 4'(grf_q); end
        g_len = (g_tens != 4'd0) ? 6'd2 : 6'd1;

        // rest marks the " <= " that follows the variable-length destination field
        rest = kind_q ? (t_len + 6'd21) : (t_len + 6'd13 + g_len);
        last = rest + 6'd12;
        nidx = idx + 6'd1;
        td   = 2'(t_len - nidx);
        tdig = bcd[{td, 2'b00} +: 4];

        nxt = "#";
        if (nidx <= t_len)                nxt = dec_char(tdig);
        else if (nidx == t_len + 6'd1)    nxt = "@";
        else if (nidx <= t_len + 6'd9)    nxt = hex_char(nib(pc_q, 3'(nidx - t_len - 6'd2)));
        else if (nidx == t_len + 6'd10)   nxt = ":";
        else if (nidx == t_len + 6'd11)   nxt = " ";
        else if (nidx == t_len + 6'd12)   nxt = kind_q ? "*" : "$";
        else if (nidx < rest) begin
            if (kind_q)                   nxt = hex_char(nib(addr_q, 3'(nidx - t_len - 6'd13)));
            else if (g_len == 6'd2 && nidx == t_len + 6'd13) nxt = dec_char(g_tens);
            else                          nxt = dec_char(g_ones);
        end
        else if (nidx == rest)            nxt = " ";
        else if (nidx == rest + 6'd1)     nxt = "<";
        else if (nidx == rest + 6'd2)     nxt = "=";
        else if (nidx == rest + 6'd3)     nxt = " ";
        else if (nidx < rest + 6'd12)     nxt = hex_char(nib(data_q, 3'(nidx - rest - 6'd4)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            kind_q  <= 1'b0;
            grf_q   <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dd      <= '0;
            cnt     <= '0;
            idx     <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    kind_q <= bus.kind;
                    grf_q  <= bus.grf;
                    pc_q   <= bus.pc;
                    addr_q <= bus.addr;
                    data_q <= bus.data;
                    dd     <= {16'h0000, sat_time(bus.ev_time)};
                    cnt    <= '0;
                    busy_q <= 1'b1;
                    state  <= CONV;
                end
                CONV: begin
                    dd  <= dabble(dd);
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        state   <= EMIT;
                        idx     <= '0;
                        char_q  <= "^";
                        valid_q <= 1'b1;
                    end
                end
                EMIT: if (bus.char_ready) begin
                    if (idx == last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        char_q <= nxt;
                        idx    <= nidx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.char       = char_q;
    assign bus.char_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: full lines compared against hand-written
// expected strings, with backpressure, busy-start and async-reset scenarios.
module tb_cpu_trace_emitter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cpu_trace_emitter_if bus();
    cpu_trace_emitter #(.TIME_MAX(9999)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int first_diff(input string a, input string b);
        int n;
        n = (a.len() < b.len()) ? a.len() : b.len();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.len() != b.len()) return n;
        return -1;
    endfunction

    task automatic set_fields(input bit k, input int t, input logic [31:0] p,
                              input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
        bus.kind = k; bus.ev_time = 14'(t); bus.pc = p; bus.grf = g; bus.addr = a; bus.data = d;
    endtask

    // Called at a negedge with the clock idle; start is accepted on the next posedge.
    task automatic run_line(input string tag, input string exp, input bit rnd, input bit mid);
        string      got = "";
        int         first = -1;
        int         dones = 0;
        int         unstable = 0;
        bit         held = 0;
        bit         fin = 0;
        logic [7:0] hc = 8'h00;
        logic [7:0] last = 8'h00;
        bus.start = 1'b1;
        for (int k = 0; k < 600 && !fin; k++) begin
            @(negedge clk);
            if (k == 0 || k == 21) bus.start = 1'b0;
            if (mid && k == 20) begin
                bus.start = 1'b1;
                set_fields(1'b1, 77, 32'h11111111, 5'd3, 32'h22222222, 32'h33333333);
            end
            if (bus.done) begin
                dones++;
                fin = 1;
                chk({tag, ".done_on_hash"}, last, 8'h23);
                chk({tag, ".busy_at_done"}, bus.busy, 0);
                chk({tag, ".valid_at_done"}, bus.char_valid, 0);
            end else if (bus.char_valid) begin
                if (first < 0) first = k;
                if (held && bus.char != hc) unstable++;
                bus.char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.char_ready) begin
                    got  = $sformatf("%s%c", got, bus.char);
                    last = bus.char;
                    held = 0;
                end else begin
                    held = 1;
                    hc   = bus.char;
                end
            end
        end
        if (!fin) chk({tag, ".timeout"}, 0, 1);
        chk({tag, ".latency"}, first, 14);
        chk({tag, ".len"}, got.len(), exp.len());
        chk({tag, ".text_first_diff"}, first_diff(got, exp), -1);
        if (got != exp) $display("  %s got  \"%s\"\n  %s want \"%s\"", tag, got, tag, exp);
        chk({tag, ".dones"}, dones, 1);
        chk({tag, ".stable"}, unstable, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.char_ready = 1'b0;
        set_fields(1'b0, 0, 32'h0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst.char", bus.char, 8'h00);
        chk("rst.valid", bus.char_valid, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        reset = 1'b0;
        @(negedge clk);

        set_fields(1'b0, 5, 32'h00003000, 5'd8, 32'h0, 32'h0000abcd);
        run_line("reg", "^5@00003000: $8 <= 0000abcd#", 1'b0, 1'b0);
        set_fields(1'b1, 1234, 32'hbfc00000, 5'd0, 32'h00001ffc, 32'hdeadbeef);
        run_line("mem", "^1234@bfc00000: *00001ffc <= deadbeef#", 1'b0, 1'b0);
        set_fields(1'b0, 0, 32'h12345678, 5'd0, 32'h0, 32'h9abcdef0);
        run_line("zero", "^0@12345678: $0 <= 9abcdef0#", 1'b0, 1'b0);
        set_fields(1'b0, 12000, 32'hffffffff, 5'd31, 32'h0, 32'h00000000);
        run_line("sat", "^9999@ffffffff: $31 <= 00000000#", 1'b0, 1'b0);
        set_fields(1'b0, 100, 32'ha5a5a5a5, 5'd10, 32'h0, 32'h0f0f0f0f);
        run_line("inner0", "^100@a5a5a5a5: $10 <= 0f0f0f0f#", 1'b0, 1'b0);

        set_fields(1'b1, 1234, 32'hbfc00000, 5'd0, 32'h00001ffc, 32'hdeadbeef);
        run_line("bp", "^1234@bfc00000: *00001ffc <= deadbeef#", 1'b1, 1'b0);

        set_fields(1'b0, 5, 32'h00003000, 5'd8, 32'h0, 32'h0000abcd);
        run_line("busy", "^5@00003000: $8 <= 0000abcd#", 1'b0, 1'b1);
        set_fields(1'b1, 1234, 32'hbfc00000, 5'd0, 32'h00001ffc, 32'hdeadbeef);
        run_line("b2b", "^1234@bfc00000: *00001ffc <= deadbeef#", 1'b0, 1'b0);

        // Abandon a line with an asynchronous reset while the pc field is streaming.
        set_fields(1'b0, 42, 32'hcafef00d, 5'd7, 32'h0, 32'h00000001);
        bus.char_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (18) @(negedge clk);
        chk("arst.pre_char", bus.char, 8'h63);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst.valid", bus.char_valid, 0);
        chk("arst.busy", bus.busy, 0);
        chk("arst.done", bus.done, 0);
        chk("arst.char", bus.char, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.char_valid) stray++;
        end
        chk("arst.quiet", stray, 0);
        run_line("arst.after", "^42@cafef00d: $7 <= 00000001#", 1'b0, 1'b0);
        @(negedge clk);
        chk("end.done_low", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
